// File: rtl/pio_seq_pkg.sv
// pio_seq_pkg
// Shared definitions for the PIO pattern sequencer: register word addresses,
// CTRL/STATUS bit positions and the sequencer state encoding.
package pio_seq_pkg;

  localparam logic [3:0] ADDR_CTRL     = 4'd0;
  localparam logic [3:0] ADDR_DWELL    = 4'd1;
  localparam logic [3:0] ADDR_LENGTH   = 4'd2;
  localparam logic [3:0] ADDR_STATUS   = 4'd3;
  localparam logic [3:0] ADDR_IDLE     = 4'd4;
  localparam logic [3:0] ADDR_PAT_BASE = 4'd8;

  // CTRL write bits
  localparam int CTRL_START  = 0;
  localparam int CTRL_STOP   = 1;
  localparam int CTRL_LOOP   = 2;
  localparam int CTRL_IRQ_EN = 3;
  // CTRL read bits
  localparam int CTRL_BUSY   = 0;

  // STATUS bits
  localparam int STATUS_DONE = 8;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

endpackage

// File: rtl/pio_seq_timer.sv
// pio_seq_timer
// Loadable down-counter used as the per-step dwell timer.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   load         : load load_val on this edge (takes priority over counting)
//   load_val     : value loaded into the counter
//   tc           : terminal count, high while the counter is zero
module pio_seq_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  // Counts down to zero and parks there until the next load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/pio_pattern_sequencer.sv
// pio_pattern_sequencer
// Avalon-MM slave that steps an output port through a programmable pattern
// table, holding each entry for a programmable dwell time, once or looping.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   address             : register word address (4 bits)
//   chipselect, write_n : write accepted when chipselect && !write_n
//   writedata           : 32-bit write data
//   readdata            : combinational, zero-latency read data
//   out_port            : registered pattern output
//   irq                 : level interrupt, done && irq_en
module pio_pattern_sequencer
  import pio_seq_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int DATA_W  = 8,
  parameter int DWELL_W = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] out_port,
  output logic              irq
);

  localparam int         IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH4 = 4'(DEPTH);

  state_t              state;
  logic [DATA_W-1:0]   pattern [DEPTH];
  logic [DATA_W-1:0]   idle_val;
  logic [DWELL_W-1:0]  dwell;
  logic [3:0]          length;
  logic                loop_en;
  logic                irq_en;
  logic                done;
  logic [2:0]          step;

  logic                wr_en;
  logic                ctrl_wr;
  logic                status_wr;
  logic                idle_wr;
  logic                pat_sel;
  logic [IDX_W-1:0]    pat_idx;
  logic                start_ok;
  logic                stop_req;
  logic                pass_end;
  logic [IDX_W-1:0]    next_idx;
  logic [DWELL_W-1:0]  dwell_m1;
  logic [DATA_W-1:0]   idle_next;
  logic                tmr_load;
  logic                tmr_tc;
  logic                unused_wdata;

  assign wr_en     = chipselect && !write_n;
  assign ctrl_wr   = wr_en && (address == ADDR_CTRL);
  assign status_wr = wr_en && (address == ADDR_STATUS);
  assign idle_wr   = wr_en && (address == ADDR_IDLE);
  assign pat_sel   = (address >= ADDR_PAT_BASE) && ((address - ADDR_PAT_BASE) < DEPTH4);
  assign pat_idx   = IDX_W'(address - ADDR_PAT_BASE);

  // Stop wins over start in the same write; a zero length makes start a no-op.
  assign stop_req  = ctrl_wr && writedata[CTRL_STOP];
  assign start_ok  = ctrl_wr && writedata[CTRL_START] && !writedata[CTRL_STOP] && (length != 4'd0);

  // Evaluated against the live length so a shortened table during a run ends
  // the pass cleanly instead of running off the end.
  assign pass_end  = ({1'b0, step} + 4'd1) >= length;
  assign next_idx  = IDX_W'(step + 3'd1);

  // A stored dwell of 0 behaves as 1, so the reload value is never negative.
  assign dwell_m1  = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

  // An IDLE_VAL write landing on the completion/stop edge is honoured at once.
  assign idle_next = idle_wr ? writedata[DATA_W-1:0] : idle_val;

  assign tmr_load  = start_ok ||
                     ((state == ST_RUN) && !stop_req && tmr_tc && (!pass_end || loop_en));

  assign unused_wdata = ^writedata;

  pio_seq_timer #(.W(DWELL_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (dwell_m1),
    .tc       (tmr_tc)
  );

  // Software-visible configuration registers and the pattern table.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) pattern[i] <= '0;
      idle_val <= '0;
      dwell    <= DWELL_W'(1);
      length   <= 4'd1;
      loop_en  <= 1'b0;
      irq_en   <= 1'b0;
    end else if (wr_en) begin
      if (address == ADDR_CTRL) begin
        loop_en <= writedata[CTRL_LOOP];
        irq_en  <= writedata[CTRL_IRQ_EN];
      end
      if (address == ADDR_DWELL) dwell <= writedata[DWELL_W-1:0];
      if (address == ADDR_LENGTH) begin
        length <= (writedata[3:0] > DEPTH4) ? DEPTH4 : writedata[3:0];
      end
      if (address == ADDR_IDLE) idle_val <= writedata[DATA_W-1:0];
      if (pat_sel) pattern[pat_idx] <= writedata[DATA_W-1:0];
    end
  end

  // Sequencer FSM. The done clear sits before the hardware set so that a set
  // on the same edge wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      step     <= '0;
      out_port <= '0;
      done     <= 1'b0;
    end else begin
      if (status_wr && writedata[STATUS_DONE]) done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state    <= ST_RUN;
            step     <= '0;
            out_port <= pattern[0];
          end else if (idle_wr) begin
            out_port <= writedata[DATA_W-1:0];
          end
        end
        ST_RUN: begin
          if (stop_req) begin
            state    <= ST_IDLE;
            step     <= '0;
            out_port <= idle_next;
          end else if (start_ok) begin
            step     <= '0;
            out_port <= pattern[0];
          end else if (tmr_tc) begin
            if (!pass_end) begin
              step     <= step + 3'd1;
              out_port <= pattern[next_idx];
            end else if (loop_en) begin
              step     <= '0;
              out_port <= pattern[0];
            end else begin
              state    <= ST_IDLE;
              out_port <= idle_next;
              done     <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Zero-latency read mux; unmapped addresses read as zero.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL: begin
        readdata[CTRL_BUSY]   = (state == ST_RUN);
        readdata[CTRL_LOOP]   = loop_en;
        readdata[CTRL_IRQ_EN] = irq_en;
      end
      ADDR_DWELL:  readdata[DWELL_W-1:0] = dwell;
      ADDR_LENGTH: readdata[3:0] = length;
      ADDR_STATUS: begin
        readdata[2:0]         = step;
        readdata[STATUS_DONE] = done;
      end
      ADDR_IDLE:   readdata[DATA_W-1:0] = idle_val;
      default: begin
        if (pat_sel) readdata[DATA_W-1:0] = pattern[pat_idx];
      end
    endcase
  end

  assign irq = done && irq_en;

endmodule

// File: tb/tb_pio_pattern_sequencer.sv
// tb_pio_pattern_sequencer
// Directed bench for pio_pattern_sequencer: a vector table covering reset
// values, table programming and a one-shot run, followed by hand-written
// sequences for looping/stop, clamped length, start corner cases, done/irq
// races and asynchronous reset.
module tb_pio_pattern_sequencer;
  import pio_seq_pkg::*;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rd_mask;
    logic [31:0] exp_rd;
    logic [7:0]  exp_out;
    logic        exp_irq;
  } vec_t;

  logic        clk;
  logic        reset_n;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        irq;

  int   n_checks;
  int   n_fail;
  vec_t vecs[$];
  logic [7:0] pat [8];

  pio_pattern_sequencer #(.DEPTH(8), .DATA_W(8), .DWELL_W(24)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One bus cycle: present inputs, let one rising edge consume them, then
  // sample 1 time unit later with the address still held.
  task automatic applyStimulus(input logic wr, input logic [3:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = !wr;
    address    = a;
    writedata  = d;
    @(posedge clk);
    #1;
    write_n    = 1'b1;
    chipselect = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkPort(input string name, input logic [7:0] exp_out, input logic exp_irq);
    checkOutput({name, " out_port"}, {24'd0, out_port}, {24'd0, exp_out});
    checkOutput({name, " irq"}, {31'd0, irq}, {31'd0, exp_irq});
  endtask

  task automatic checkRd(input string name, input logic [31:0] mask, input logic [31:0] exp);
    checkOutput({name, " readdata"}, readdata & mask, exp & mask);
  endtask

  function automatic void addVec(input logic wr, input logic [3:0] a, input logic [31:0] d,
                                 input logic [31:0] m, input logic [31:0] er,
                                 input logic [7:0] eo, input logic ei);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = d; v.rd_mask = m;
    v.exp_rd = er; v.exp_out = eo; v.exp_irq = ei;
    vecs.push_back(v);
  endfunction

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 4'd0;
    writedata  = 32'd0;
    pat[0] = 8'h01; pat[1] = 8'h02; pat[2] = 8'h04; pat[3] = 8'h08;
    pat[4] = 8'h10; pat[5] = 8'h20; pat[6] = 8'h40; pat[7] = 8'h80;

    // Reset register map: all zero except DWELL=1 and LENGTH=1.
    for (int a = 0; a < 16; a++) begin
      addVec(1'b0, 4'(a), 32'd0, 32'hFFFF_FFFF, (a == 1 || a == 2) ? 32'd1 : 32'd0, 8'h00, 1'b0);
    end
    // Program pattern 0..3, DWELL=3, LENGTH=4; unmapped write ignored.
    addVec(1'b1, 4'd8,  32'h01, 32'hFFFF_FFFF, 32'h01, 8'h00, 1'b0);
    addVec(1'b1, 4'd9,  32'h02, 32'hFFFF_FFFF, 32'h02, 8'h00, 1'b0);
    addVec(1'b1, 4'd10, 32'h04, 32'hFFFF_FFFF, 32'h04, 8'h00, 1'b0);
    addVec(1'b1, 4'd11, 32'h08, 32'hFFFF_FFFF, 32'h08, 8'h00, 1'b0);
    addVec(1'b1, 4'd1,  32'd3,  32'hFFFF_FFFF, 32'd3,  8'h00, 1'b0);
    addVec(1'b1, 4'd2,  32'd4,  32'hFFFF_FFFF, 32'd4,  8'h00, 1'b0);
    addVec(1'b1, 4'd6,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 8'h00, 1'b0);
    // One-shot start: busy, first entry visible right after the start edge.
    addVec(1'b1, 4'd0,  32'h1, 32'hFFFF_FFFF, 32'h1, 8'h01, 1'b0);
    // Each entry holds for exactly 3 edges; STATUS shows step, done clear.
    for (int k = 1; k < 12; k++) begin
      addVec(1'b0, 4'd3, 32'd0, 32'h0000_0107, 32'(k / 3), pat[k / 3], 1'b0);
    end
    // Edge 12 from start: back to IDLE_VAL (0), not busy, done set.
    addVec(1'b0, 4'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 8'h00, 1'b0);
    addVec(1'b0, 4'd3, 32'd0, 32'h0000_0100, 32'h100, 8'h00, 1'b0);

    #12;
    checkPort("reset", 8'h00, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      checkRd($sformatf("vec%0d", i), vecs[i].rd_mask, vecs[i].exp_rd);
      checkPort($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_irq);
    end

    // Loop + irq_en, then stop after 20 cycles.
    applyStimulus(1'b1, ADDR_IDLE, 32'hA5);
    checkPort("idle write", 8'hA5, 1'b0);
    applyStimulus(1'b1, ADDR_STATUS, 32'h100);
    checkRd("done clear", 32'h100, 32'h0);
    applyStimulus(1'b1, ADDR_CTRL, 32'hD);
    checkRd("loop start ctrl", 32'hFFFF_FFFF, 32'hD);
    checkPort("loop k0", 8'h01, 1'b0);
    for (int k = 1; k < 20; k++) begin
      applyStimulus(1'b0, ADDR_STATUS, 32'd0);
      checkPort($sformatf("loop k%0d", k), pat[(k / 3) % 4], 1'b0);
      checkRd($sformatf("loop step k%0d", k), 32'h7, 32'((k / 3) % 4));
    end
    applyStimulus(1'b1, ADDR_CTRL, 32'hE);
    checkPort("loop stop", 8'hA5, 1'b0);
    checkRd("loop stop ctrl", 32'hFFFF_FFFF, 32'hC);
    applyStimulus(1'b0, ADDR_STATUS, 32'd0);
    checkRd("loop stop status", 32'h107, 32'h0);

    // DWELL=0, LENGTH=9 clamps to 8: one cycle per step, 8 steps.
    for (int i = 4; i < 8; i++) applyStimulus(1'b1, 4'(8 + i), {24'd0, pat[i]});
    applyStimulus(1'b1, ADDR_DWELL, 32'd0);
    applyStimulus(1'b1, ADDR_LENGTH, 32'd9);
    applyStimulus(1'b1, ADDR_CTRL, 32'h1);
    checkPort("fast k0", 8'h01, 1'b0);
    for (int k = 1; k < 8; k++) begin
      applyStimulus(1'b0, ADDR_STATUS, 32'd0);
      checkPort($sformatf("fast k%0d", k), pat[k], 1'b0);
    end
    checkRd("fast done k7", 32'h100, 32'h0);
    applyStimulus(1'b0, ADDR_STATUS, 32'd0);
    checkPort("fast k8", 8'hA5, 1'b0);
    checkRd("fast done k8", 32'h100, 32'h100);

    // Start corner cases.
    applyStimulus(1'b1, ADDR_LENGTH, 32'd0);
    applyStimulus(1'b1, ADDR_CTRL, 32'h1);
    checkRd("len0 start busy", 32'hFFFF_FFFF, 32'h0);
    checkPort("len0 start", 8'hA5, 1'b0);
    applyStimulus(1'b1, ADDR_LENGTH, 32'd4);
    applyStimulus(1'b1, ADDR_DWELL, 32'd3);
    applyStimulus(1'b1, ADDR_CTRL, 32'h3);
    checkRd("start+stop busy", 32'hFFFF_FFFF, 32'h0);
    applyStimulus(1'b0, ADDR_CTRL, 32'd0);
    checkPort("start+stop", 8'hA5, 1'b0);
    applyStimulus(1'b1, ADDR_CTRL, 32'h1);
    checkPort("restart k0", 8'h01, 1'b0);
    for (int k = 1; k < 4; k++) applyStimulus(1'b0, ADDR_STATUS, 32'd0);
    checkPort("restart k3", 8'h02, 1'b0);
    applyStimulus(1'b1, ADDR_CTRL, 32'h1);
    checkPort("restart edge", 8'h01, 1'b0);
    applyStimulus(1'b0, ADDR_STATUS, 32'd0);
    checkRd("restart status", 32'h107, 32'h100);
    applyStimulus(1'b0, ADDR_STATUS, 32'd0);
    checkPort("restart k2", 8'h01, 1'b0);
    applyStimulus(1'b0, ADDR_STATUS, 32'd0);
    checkPort("restart k3b", 8'h02, 1'b0);
    applyStimulus(1'b1, ADDR_CTRL, 32'h2);
    checkPort("restart stop", 8'hA5, 1'b0);

    // irq on one-shot completion, then a clear racing a new completion.
    applyStimulus(1'b1, ADDR_STATUS, 32'h100);
    applyStimulus(1'b1, ADDR_CTRL, 32'h9);
    checkPort("irq k0", 8'h01, 1'b0);
    for (int k = 1; k < 12; k++) applyStimulus(1'b0, ADDR_STATUS, 32'd0);
    checkPort("irq k11", 8'h08, 1'b0);
    applyStimulus(1'b0, ADDR_STATUS, 32'd0);
    checkPort("irq k12", 8'hA5, 1'b1);
    applyStimulus(1'b1, ADDR_CTRL, 32'h9);
    checkPort("irq restart", 8'h01, 1'b1);
    for (int k = 1; k < 12; k++) applyStimulus(1'b0, ADDR_STATUS, 32'd0);
    applyStimulus(1'b1, ADDR_STATUS, 32'h100);
    checkRd("done race", 32'h100, 32'h100);
    checkPort("done race", 8'hA5, 1'b1);
    applyStimulus(1'b1, ADDR_STATUS, 32'h100);
    checkRd("done cleared", 32'h100, 32'h0);
    checkPort("done cleared", 8'hA5, 1'b0);

    // Asynchronous reset mid-run.
    applyStimulus(1'b1, ADDR_CTRL, 32'h1);
    for (int k = 1; k < 5; k++) applyStimulus(1'b0, ADDR_STATUS, 32'd0);
    checkPort("pre-reset k4", 8'h02, 1'b0);
    #1;
    reset_n = 1'b0;
    #1;
    checkPort("async reset", 8'h00, 1'b0);
    checkRd("async reset status", 32'hFFFF_FFFF, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    applyStimulus(1'b0, ADDR_CTRL, 32'd0);
    checkRd("post-reset ctrl", 32'hFFFF_FFFF, 32'h0);
    applyStimulus(1'b0, ADDR_DWELL, 32'd0);
    checkRd("post-reset dwell", 32'hFFFF_FFFF, 32'h1);
    applyStimulus(1'b0, ADDR_IDLE, 32'd0);
    checkRd("post-reset idle", 32'hFFFF_FFFF, 32'h0);
    applyStimulus(1'b0, 4'd8, 32'd0);
    checkRd("post-reset pat0", 32'hFFFF_FFFF, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
